uart_tx_engine: RTL

- 8N1 UART transmit serializer with a small byte FIFO.
- Sits directly downstream of the UART register window. Each accepted TXDATA byte is pushed here, and the block drives the uart_tx pin.
- Replaces the constant-idle tx pin with real framed serial output at a programmable baud divider.

---
 rtl/uart_tx_engine_if.sv | 28 ++
 rtl/uart_tx_engine.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_engine_if.sv
// -----------------------------------------------------------------------------
// uart_tx_engine_if
// Byte push handshake between the UART register window and the transmit
// engine. A byte transfers on a rising clock edge where tx_valid && tx_ready.
//   tx_valid : push request (register window -> engine)
//   tx_data  : byte to queue (register window -> engine)
//   tx_ready : engine FIFO can accept (engine -> register window)
// Modports: master = register window side, slave = transmit engine side.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface uart_tx_engine_if;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;

    modport master (
        output tx_valid,
        output tx_data,
        input  tx_ready
    );

    modport slave (
        input  tx_valid,
        input  tx_data,
        output tx_ready
    );
endinterface

// File: rtl/uart_tx_engine.sv
// -----------------------------------------------------------------------------
// uart_tx_engine
// 8N1 UART transmit serializer fed by a small byte FIFO. Bytes pushed through
// tx_if are queued and sent LSB first on uart_tx at baud_div+1 clocks per bit.
// Back-to-back frames run without an idle bit between the stop and next start.
//
// Ports:
//   clk        : core clock
//   rst_n      : asynchronous active-low reset
//   tx_if      : byte push handshake (slave modport: tx_valid, tx_data, tx_ready)
//   enable     : transmitter enable; gates only the start of new frames
//   baud_div   : bit period minus one in clocks, captured when a byte is popped
//   parity_en  : (UART_TX_PARITY_EN only) insert parity bit, captured at pop
//   parity_odd : (UART_TX_PARITY_EN only) odd instead of even parity
//   uart_tx    : serial line, idle high
//   busy       : a frame is in progress
//   fifo_level : bytes currently queued
//   fifo_empty : fifo_level == 0
//   fifo_full  : fifo_level == FIFO_DEPTH
//
// Build option: define UART_TX_PARITY_EN to add the parity ports and a
// PARITY bit between the data bits and the stop bit.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_tx_engine #(
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    uart_tx_engine_if.slave               tx_if,
    input  logic                          enable,
    input  logic [DIV_W-1:0]              baud_div,
`ifdef UART_TX_PARITY_EN
    input  logic                          parity_en,
    input  logic                          parity_odd,
`endif
    output logic                          uart_tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          fifo_empty,
    output logic                          fifo_full
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    // ---------------------------------------------------------------- FIFO
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic          push;
    logic          pop;
    logic [7:0]    head;

    // Pointers carry one extra wrap bit, so full and empty are told apart
    // by the difference alone.
    assign fifo_level = wr_ptr_reg - rd_ptr_reg;
    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (fifo_level == PW'(FIFO_DEPTH));
    assign tx_if.tx_ready = !fifo_full;
    assign push = tx_if.tx_valid && !fifo_full;
    assign head = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg[AW-1:0]] <= tx_if.tx_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
        end
    end

    // ---------------------------------------------------------- serializer
    state_t         state_reg,    state_next;
    logic [DIV_W-1:0] baud_cnt_reg, baud_cnt_next;
    logic [DIV_W-1:0] div_reg,    div_next;
    logic [2:0]     bit_cnt_reg,  bit_cnt_next;
    logic [7:0]     shift_reg,    shift_next;
`ifdef UART_TX_PARITY_EN
    logic           par_en_reg,   par_en_next;
    logic           par_bit_reg,  par_bit_next;
`endif
    logic           bit_end;
    logic           can_pop;

    // Counting up to the latched divisor and restarting at zero keeps the
    // counter within DIV_W bits even for an all-ones divisor.
    assign bit_end = (baud_cnt_reg == div_reg);
    assign can_pop = enable && !fifo_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            baud_cnt_reg <= '0;
            div_reg      <= '0;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
`ifdef UART_TX_PARITY_EN
            par_en_reg   <= 1'b0;
            par_bit_reg  <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            baud_cnt_reg <= baud_cnt_next;
            div_reg      <= div_next;
            bit_cnt_reg  <= bit_cnt_next;
            shift_reg    <= shift_next;
`ifdef UART_TX_PARITY_EN
            par_en_reg   <= par_en_next;
            par_bit_reg  <= par_bit_next;
`endif
        end
    end

    always_comb begin
        state_next    = state_reg;
        baud_cnt_next = (state_reg == IDLE || bit_end) ? '0 : baud_cnt_reg + DIV_W'(1);
        div_next      = div_reg;
        bit_cnt_next  = bit_cnt_reg;
        shift_next    = shift_reg;
        pop           = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_en_next   = par_en_reg;
        par_bit_next  = par_bit_reg;
`endif

        case (state_reg)
            IDLE: begin
                if (can_pop) begin
                    pop        = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                if (bit_end) state_next = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    shift_next = {1'b0, shift_reg[7:1]};
                    if (bit_cnt_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_next = par_en_reg ? PARITY : STOP;
`else
                        state_next = STOP;
`endif
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) state_next = STOP;
            end
`endif
            STOP: begin
                if (bit_end) begin
                    // Chain straight into the next start bit when more data waits.
                    if (can_pop) begin
                        pop        = 1'b1;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // Frame setup shared by both pop points: everything the frame needs
        // is captured here so later input changes cannot disturb it.
        if (pop) begin
            shift_next    = head;
            div_next      = baud_div;
            bit_cnt_next  = '0;
            baud_cnt_next = '0;
`ifdef UART_TX_PARITY_EN
            par_en_next   = parity_en;
            par_bit_next  = (^head) ^ parity_odd;
`endif
        end
    end

    // Line level decoded from state registers only.
    always_comb begin
        uart_tx = 1'b1;
        case (state_reg)
            IDLE:   uart_tx = 1'b1;
            START:  uart_tx = 1'b0;
            DATA:   uart_tx = shift_reg[0];
`ifdef UART_TX_PARITY_EN
            PARITY: uart_tx = par_bit_reg;
`endif
            STOP:   uart_tx = 1'b1;
            default: uart_tx = 1'b1;
        endcase
    end

    assign busy = (state_reg != IDLE);

endmodule
